// File: rtl/vga_framebuffer_reader.sv
// VGA scan-out of a double-buffered 1bpp framebuffer, pixel clock = clk/2.
// Each tick has two stages: issue the read address, then register colour/sync/blank together.
module vga_framebuffer_reader #(
    parameter logic [23:0] FG_COLOR  = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR  = 24'h000000,
    parameter int          H_VISIBLE = 640,
    parameter int          H_FRONT   = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BACK    = 48,
    parameter int          V_VISIBLE = 480,
    parameter int          V_FRONT   = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BACK    = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        display_buf,
    output logic [19:0] rd_addr,
    input  logic        rd_data,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        frame_start
);

    localparam logic [9:0]  H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0]  H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]  H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0]  H_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0]  V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0]  V_VIS_LAST = 10'(V_VISIBLE - 1);
    localparam logic [9:0]  V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0]  V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [18:0] ROW_STRIDE = 19'(H_VISIBLE);

    logic        phase_q;
    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic [18:0] row_base_q, row_base_d;
    logic [19:0] rd_addr_q, rd_addr_d;
    logic        active1_q, active1_d;
    logic        hs1_q, hs1_d;
    logic        vs1_q, vs1_d;
    logic [23:0] rgb_q, rgb_d;
    logic        blank_n_q, blank_n_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        disp_q, disp_d;
    logic        swap_ack_q, swap_ack_d;

    logic tick;
    logic h_wrap;
    logic v_wrap;
    logic visible;
    logic in_hsync;
    logic in_vsync;
    logic at_swap_point;

    assign tick          = phase_q;
    assign h_wrap        = (h_q == H_LAST);
    assign v_wrap        = (v_q == V_LAST);
    assign visible       = (h_q < H_VIS_END) && (v_q < V_VIS_END);
    assign in_hsync      = (h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END);
    assign in_vsync      = (v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END);
    // Swap only at the start of vsync so the visible region never sees a buffer change.
    assign at_swap_point = (h_q == 10'd0) && (v_q == V_SYNC_BEG);

    always_comb begin
        h_d        = h_q;
        v_d        = v_q;
        row_base_d = row_base_q;
        rd_addr_d  = rd_addr_q;
        active1_d  = active1_q;
        hs1_d      = hs1_q;
        vs1_d      = vs1_q;
        rgb_d      = rgb_q;
        blank_n_d  = blank_n_q;
        hs_d       = hs_q;
        vs_d       = vs_q;
        disp_d     = disp_q;
        swap_ack_d = 1'b0;

        if (tick) begin
            h_d = h_wrap ? 10'd0 : h_q + 10'd1;
            if (h_wrap) begin
                v_d        = v_wrap ? 10'd0 : v_q + 10'd1;
                row_base_d = (v_q < V_VIS_LAST) ? row_base_q + ROW_STRIDE : 19'd0;
            end

            if (visible) begin
                rd_addr_d = {disp_q, row_base_q + 19'(h_q)};
            end
            active1_d = visible;
            hs1_d     = ~in_hsync;
            vs1_d     = ~in_vsync;

            rgb_d     = active1_q ? (rd_data ? FG_COLOR : BG_COLOR) : 24'd0;
            blank_n_d = active1_q;
            hs_d      = hs1_q;
            vs_d      = vs1_q;

            if (at_swap_point && swap_req) begin
                disp_d     = ~disp_q;
                swap_ack_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q    <= 1'b0;
            h_q        <= 10'd0;
            v_q        <= 10'd0;
            row_base_q <= 19'd0;
            rd_addr_q  <= 20'd0;
            active1_q  <= 1'b0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            rgb_q      <= 24'd0;
            blank_n_q  <= 1'b0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            disp_q     <= 1'b0;
            swap_ack_q <= 1'b0;
        end else begin
            phase_q    <= ~phase_q;
            h_q        <= h_d;
            v_q        <= v_d;
            row_base_q <= row_base_d;
            rd_addr_q  <= rd_addr_d;
            active1_q  <= active1_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            rgb_q      <= rgb_d;
            blank_n_q  <= blank_n_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            disp_q     <= disp_d;
            swap_ack_q <= swap_ack_d;
        end
    end

    assign swap_ack    = swap_ack_q;
    assign display_buf = disp_q;
    assign rd_addr     = rd_addr_q;
    assign VGA_CLK     = phase_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];
    // High during the clk that ends in the (0,0) tick.
    assign frame_start = tick && (h_q == 10'd0) && (v_q == 10'd0);

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// Directed bench: full-timing instance for line-level behaviour, shrunken-timing instance
// for frame-level behaviour (vsync, swap, frame_start period, mid-frame reset).
module tb_vga_framebuffer_reader;

    logic clk        = 1'b0;
    logic reset      = 1'b0;
    logic swap_req_f = 1'b0;
    logic swap_req_s = 1'b0;
    logic rd_data_f  = 1'b0;
    logic rd_data_s  = 1'b0;

    logic        ack_f, disp_f, vclk_f, hs_f, vs_f, blank_f, sync_f, fs_f;
    logic [19:0] addr_f;
    logic [7:0]  r_f, g_f, b_f;
    logic        ack_s, disp_s, vclk_s, hs_s, vs_s, blank_s, sync_s, fs_s;
    logic [19:0] addr_s;
    logic [7:0]  r_s, g_s, b_s;

    int cyc = 0;
    int rel, f, t0, nb, nfg;
    logic [23:0] rgb_pix;
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    vga_framebuffer_reader u_full (
        .clk(clk), .reset(reset), .swap_req(swap_req_f), .swap_ack(ack_f),
        .display_buf(disp_f), .rd_addr(addr_f), .rd_data(rd_data_f),
        .VGA_CLK(vclk_f), .VGA_HS(hs_f), .VGA_VS(vs_f), .VGA_BLANK_N(blank_f),
        .VGA_SYNC_N(sync_f), .VGA_R(r_f), .VGA_G(g_f), .VGA_B(b_f),
        .frame_start(fs_f)
    );

    vga_framebuffer_reader #(
        .FG_COLOR(24'hC0FFEE), .BG_COLOR(24'h102030),
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) u_small (
        .clk(clk), .reset(reset), .swap_req(swap_req_s), .swap_ack(ack_s),
        .display_buf(disp_s), .rd_addr(addr_s), .rd_data(rd_data_s),
        .VGA_CLK(vclk_s), .VGA_HS(hs_s), .VGA_VS(vs_s), .VGA_BLANK_N(blank_s),
        .VGA_SYNC_N(sync_s), .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s),
        .frame_start(fs_s)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Full RAM: only pixel (10,2) -> index 2*640+10 = 1290 is set. Small RAM: odd pixels set.
    always @(posedge clk) rd_data_f <= (addr_f[18:0] == 19'd1290);
    always @(posedge clk) rd_data_s <= addr_s[0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_hs_f",    32'(hs_f), 1);
        check("rst_vs_f",    32'(vs_f), 1);
        check("rst_blank_f", 32'(blank_f), 0);
        check("rst_rgb_f",   32'({r_f, g_f, b_f}), 0);
        check("rst_vclk_f",  32'(vclk_f), 0);
        check("rst_sync_f",  32'(sync_f), 0);
        check("rst_fs_f",    32'(fs_f), 0);
        check("rst_ack_f",   32'(ack_f), 0);
        check("rst_addr_f",  32'(addr_f), 0);
        check("rst_disp_f",  32'(disp_f), 0);
        check("rst_rgb_s",   32'({r_s, g_s, b_s}), 0);

        reset = 1'b1;
        rel   = cyc;

        wait_cyc(rel + 1);
        check("fs_first_tick", 32'(fs_f), 1);
        check("vclk_hi",       32'(vclk_f), 1);
        wait_cyc(rel + 2);
        check("vclk_lo",       32'(vclk_f), 0);
        check("fs_one_clk",    32'(fs_f), 0);

        while (hs_f !== 1'b0 && cyc - rel < 1400) @(negedge clk);
        check("hs_fall_clks", cyc - rel, 1316);
        t0 = cyc;
        while (hs_f !== 1'b1 && cyc - t0 < 400) @(negedge clk);
        check("hs_low_clks", cyc - t0, 192);
        while (hs_f !== 1'b0 && cyc - t0 < 2000) @(negedge clk);
        check("hs_period_clks", cyc - t0, 1600);

        // Line 2 window: tick n=1600..2399 spans clk edges 3202..4800.
        wait_cyc(rel + 3201);
        nb = 0;
        nfg = 0;
        rgb_pix = 24'd0;
        while (cyc - rel <= 4800) begin
            if (blank_f === 1'b1) nb++;
            if ({r_f, g_f, b_f} !== 24'd0) nfg++;
            if (cyc - rel == 3224) rgb_pix = {r_f, g_f, b_f};
            @(negedge clk);
        end
        check("line2_blank_clks", nb, 1280);
        check("line2_fg_clks",    nfg, 2);
        check("pix_10_2_fg",      32'(rgb_pix), 32'h00FF_FFFF);

        wait_cyc(rel + 4811);
        check("addr_4_3",   32'(addr_f), 1924);
        wait_cyc(rel + 4812);
        check("addr_5_3",   32'(addr_f), 1925);
        wait_cyc(rel + 6300);
        check("addr_hold",  32'(addr_f), 2559);

        // Small instance: 24x12 total, 16x6 visible, vsync lines 8..9, frame = 576 clk.
        while (fs_s !== 1'b1 && cyc - rel < 7500) @(negedge clk);
        f = cyc;
        check("fs_s_seen", 32'(fs_s), 1);
        wait_cyc(f + 1);
        check("fs_s_pulse", 32'(fs_s), 0);
        check("addr_s_00",  32'(addr_s), 0);
        wait_cyc(f + 3);
        check("rgb_s_bg",   32'({r_s, g_s, b_s}), 32'h0010_2030);
        check("blank_s_hi", 32'(blank_s), 1);
        wait_cyc(f + 5);
        check("rgb_s_fg",   32'({r_s, g_s, b_s}), 32'h00C0_FFEE);

        wait_cyc(f + 200);
        swap_req_s = 1'b1;
        wait_cyc(f + 271);
        check("addr_s_last", 32'(addr_s), 95);
        wait_cyc(f + 384);
        check("ack_before", 32'(ack_s), 0);
        check("disp_before", 32'(disp_s), 0);
        wait_cyc(f + 385);
        check("ack_pulse",  32'(ack_s), 1);
        check("disp_swap1", 32'(disp_s), 1);
        wait_cyc(f + 386);
        check("ack_one_clk", 32'(ack_s), 0);
        check("vs_pre_fall", 32'(vs_s), 1);
        swap_req_s = 1'b0;
        wait_cyc(f + 387);
        check("vs_fall", 32'(vs_s), 0);
        wait_cyc(f + 482);
        check("vs_still_low", 32'(vs_s), 0);
        wait_cyc(f + 483);
        check("vs_rise", 32'(vs_s), 1);
        wait_cyc(f + 575);
        check("addr_s_hold", 32'(addr_s), 95);

        wait_cyc(f + 576);
        check("fs_s_period", 32'(fs_s), 1);
        wait_cyc(f + 577);
        check("addr_s_buf1", 32'(addr_s), 32'h0008_0000);
        wait_cyc(f + 961);
        check("no_swap_dropped", 32'(ack_s), 0);
        check("disp_kept",       32'(disp_s), 1);
        wait_cyc(f + 963);
        check("vs_period", 32'(vs_s), 0);

        wait_cyc(f + 1000);
        swap_req_s = 1'b1;
        wait_cyc(f + 1537);
        check("ack_held_1",  32'(ack_s), 1);
        check("disp_swap2",  32'(disp_s), 0);
        wait_cyc(f + 2113);
        check("ack_held_2",  32'(ack_s), 1);
        check("disp_swap3",  32'(disp_s), 1);
        wait_cyc(f + 2114);
        swap_req_s = 1'b0;

        wait_cyc(f + 2400);
        while (!(blank_s === 1'b1 && r_s === 8'hC0) && cyc < f + 3000) @(negedge clk);
        #3 reset = 1'b0;
        #1;
        check("arst_hs_s",    32'(hs_s), 1);
        check("arst_vs_s",    32'(vs_s), 1);
        check("arst_blank_s", 32'(blank_s), 0);
        check("arst_rgb_s",   32'({r_s, g_s, b_s}), 0);
        check("arst_addr_s",  32'(addr_s), 0);
        check("arst_disp_s",  32'(disp_s), 0);
        check("arst_addr_f",  32'(addr_f), 0);

        @(negedge clk);
        reset = 1'b1;
        rel   = cyc;
        wait_cyc(rel + 1);
        check("rel_fs_s", 32'(fs_s), 1);
        wait_cyc(rel + 2);
        check("rel_addr_s0", 32'(addr_s), 0);
        wait_cyc(rel + 4);
        check("rel_addr_s1", 32'(addr_s), 1);
        check("rel_addr_f1", 32'(addr_f), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
